// File: rtl/dpcm_pkg.sv
// Shared types, register offsets and the saturating adder for the DPCM encoder/decoder pair.
package dpcm_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_WAIT   = 2'd3
   } apb_state_t;

   localparam logic [7:0] ADDR_DATA   = 8'h00;
   localparam logic [7:0] ADDR_STATUS = 8'h04;
   localparam logic [7:0] ADDR_CTRL   = 8'h08;

   localparam int STAT_EMPTY   = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_SAT     = 2;
   localparam int STAT_CNT_LSB = 8;
   localparam int CTRL_CLEAR   = 0;
   localparam int CTRL_CLR_SAT = 1;

   // Operands are sign-extended to 64 bits by the caller; the result is clamped to a signed w-bit range.
   function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int w);
      logic signed [64:0] sum;
      logic signed [64:0] hi;
      logic signed [64:0] lo;
      sum = a;
      sum = sum + b;
      hi  = (65'sd1 <<< (w - 1)) - 65'sd1;
      lo  = -(65'sd1 <<< (w - 1));
      if (sum > hi)
         return $signed(hi[63:0]);
      else if (sum < lo)
         return $signed(lo[63:0]);
      else
         return $signed(sum[63:0]);
   endfunction

endpackage

// File: rtl/dpcm_sample_fifo.sv
// Circular FIFO holding reconstructed samples; count disambiguates full from empty.
module dpcm_sample_fifo
   import dpcm_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 8,
   localparam int PTR_W     = $clog2(FIFO_DEPTH),
   localparam int CNT_W     = PTR_W + 1
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              push_ok;
   logic              pop_ok;

   assign full    = (count == CNT_W'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full && !flush;
   assign pop_ok  = pop && !empty && !flush;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge PCLK) begin
      if (push_ok)
         mem[wr_ptr] <= din;
   end

   // Depth is a power of two, so pointer overflow is the wrap.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (push_ok && !pop_ok)
            count <= count + CNT_W'(1);
         else if (pop_ok && !push_ok)
            count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/dpcm_decoder_apb.sv
// APB slave that rebuilds DPCM samples from saturated differences and queues them for readback.
// Optional macro DPCM_DEC_WAIT_EN adds a one-cycle WAIT state to DATA reads.
module dpcm_decoder_apb
   import dpcm_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int DIFF_W     = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              PSELx,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [31:0]       PADDR,
   input  logic [DATA_W-1:0] PWDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic [DATA_W-1:0] PRDATA,
   output logic [1:0]        estados
);

`ifdef DPCM_DEC_WAIT_EN
   localparam bit WAIT_EN = 1'b1;
`else
   localparam bit WAIT_EN = 1'b0;
`endif

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic signed [63:0] DIFF_MAX = (64'sd1 <<< (DIFF_W - 1)) - 64'sd1;
   localparam logic signed [63:0] DIFF_MIN = -(64'sd1 <<< (DIFF_W - 1));

   apb_state_t               state_q, state_d;
   logic signed [DATA_W-1:0] pred_q;
   logic                     sat_sticky_q;
   logic [DATA_W-1:0]        rd_hold_q;
   logic                     done;
   logic                     err;

   logic [7:0]               addr;
   logic                     is_data, is_status, is_ctrl;
   logic                     addr_hi_unused;
   logic signed [63:0]       pred_x, diff_x, raw_sum, sat_sum;
   logic                     diff_ok, sat_hit;
   logic                     push, pop, flush, clr_sat;
   logic [DATA_W-1:0]        fifo_dout;
   logic [CNT_W-1:0]         fifo_count;
   logic                     fifo_full, fifo_empty;
   logic [DATA_W-1:0]        status_word;

   assign addr           = PADDR[7:0];
   assign addr_hi_unused = ^PADDR[31:8];
   assign is_data        = (addr == ADDR_DATA);
   assign is_status      = (addr == ADDR_STATUS);
   assign is_ctrl        = (addr == ADDR_CTRL);

   assign pred_x  = 64'(pred_q);
   assign diff_x  = 64'($signed(PWDATA));
   assign raw_sum = pred_x + diff_x;
   assign sat_sum = sat_add(pred_x, diff_x, DATA_W);
   assign sat_hit = (sat_sum != raw_sum);
   assign diff_ok = (diff_x >= DIFF_MIN) && (diff_x <= DIFF_MAX);

   assign push    = done && PWRITE && is_data && diff_ok && !fifo_full;
   assign pop     = done && !PWRITE && is_data && !fifo_empty;
   assign flush   = done && PWRITE && is_ctrl && PWDATA[CTRL_CLEAR];
   assign clr_sat = done && PWRITE && is_ctrl && PWDATA[CTRL_CLR_SAT];

   always_comb begin
      status_word                           = '0;
      status_word[STAT_EMPTY]               = fifo_empty;
      status_word[STAT_FULL]                = fifo_full;
      status_word[STAT_SAT]                 = sat_sticky_q;
      status_word[STAT_CNT_LSB +: 8]        = 8'(fifo_count);
   end

   // Commit happens only on the cycle that completes the transfer (done).
   always_comb begin
      state_d = state_q;
      PREADY  = 1'b1;
      done    = 1'b0;
      unique case (state_q)
         S_IDLE:   if (PSELx && !PENABLE) state_d = S_SETUP;
         S_SETUP:  state_d = S_ACCESS;
         S_ACCESS: begin
            if (WAIT_EN && !PWRITE && is_data) begin
               PREADY  = 1'b0;
               state_d = S_WAIT;
            end else begin
               done    = 1'b1;
               state_d = (PSELx && !PENABLE) ? S_SETUP : S_IDLE;
            end
         end
         S_WAIT: begin
            done    = 1'b1;
            state_d = (PSELx && !PENABLE) ? S_SETUP : S_IDLE;
         end
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      PRDATA = '0;
      err    = 1'b0;
      if (done) begin
         if (is_data) begin
            if (PWRITE) begin
               err = !diff_ok || fifo_full;
            end else begin
               err = fifo_empty;
               if (!fifo_empty)
                  PRDATA = WAIT_EN ? rd_hold_q : fifo_dout;
            end
         end else if (is_status) begin
            if (PWRITE)
               err = 1'b1;
            else
               PRDATA = status_word;
         end else if (!is_ctrl) begin
            err = 1'b1;
         end
      end
   end

   assign PSLVERR = err;
   assign estados = state_q;

   always_ff @(posedge PCLK) begin
      if (state_q == S_ACCESS && state_d == S_WAIT)
         rd_hold_q <= fifo_empty ? '0 : fifo_dout;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q      <= S_IDLE;
         pred_q       <= '0;
         sat_sticky_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (flush)
            pred_q <= '0;
         else if (push)
            pred_q <= sat_sum[DATA_W-1:0];
         if (clr_sat)
            sat_sticky_q <= 1'b0;
         else if (push && sat_hit)
            sat_sticky_q <= 1'b1;
      end
   end

   dpcm_sample_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .push    (push),
      .pop     (pop),
      .flush   (flush),
      .din     (sat_sum[DATA_W-1:0]),
      .dout    (fifo_dout),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

endmodule

// File: tb/tb_dpcm_decoder_apb.sv
// Directed bench for dpcm_decoder_apb with a queue scoreboard of reconstructed samples.
module tb_dpcm_decoder_apb;

   localparam int DW    = 16;
   localparam int DEPTH = 8;
   localparam int SMAX  = 32767;
   localparam int SMIN  = -32768;

   logic          PCLK = 1'b0;
   logic          PRESETn;
   logic          PSELx, PENABLE, PWRITE;
   logic [31:0]   PADDR;
   logic [DW-1:0] PWDATA;
   logic          PREADY, PSLVERR;
   logic [DW-1:0] PRDATA;
   logic [1:0]    estados;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            pred_m   = 0;
   bit            sat_m    = 1'b0;
   logic [DW-1:0] sb[$];

   dpcm_decoder_apb #(.DATA_W(DW), .DIFF_W(8), .FIFO_DEPTH(DEPTH)) dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .PSELx   (PSELx),
      .PENABLE (PENABLE),
      .PWRITE  (PWRITE),
      .PADDR   (PADDR),
      .PWDATA  (PWDATA),
      .PREADY  (PREADY),
      .PSLVERR (PSLVERR),
      .PRDATA  (PRDATA),
      .estados (estados)
   );

   always #5 PCLK = ~PCLK;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apb(input logic wr, input logic [7:0] addr, input logic [DW-1:0] wd,
                      output logic [DW-1:0] rd, output logic err);
      bit done;
      done = 1'b0;
      rd   = '0;
      err  = 1'b0;
      @(posedge PCLK); #1;
      PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = {24'h0, addr}; PWDATA = wd;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      for (int i = 0; i < 8 && !done; i++) begin
         @(negedge PCLK);
         if (PREADY && (estados == 2'd2 || estados == 2'd3)) begin
            done = 1'b1;
            rd   = PRDATA;
            err  = PSLVERR;
         end
      end
      @(posedge PCLK); #1;
      PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      check("apb_complete", 32'(done), 32'd1);
   endtask

   task automatic wr_data(input int d);
      logic [DW-1:0] rd;
      logic          err;
      logic [DW-1:0] wv;
      bit            exp_err;
      int            s;
      wv      = d[DW-1:0];
      exp_err = (d > 127) || (d < -128) || (sb.size() == DEPTH);
      apb(1'b1, 8'h00, wv, rd, err);
      check("wr_data_err", 32'(err), 32'(exp_err));
      if (!exp_err) begin
         s = pred_m + d;
         if (s > SMAX) begin s = SMAX; sat_m = 1'b1; end
         if (s < SMIN) begin s = SMIN; sat_m = 1'b1; end
         pred_m = s;
         sb.push_back(s[DW-1:0]);
      end
   endtask

   task automatic rd_data();
      logic [DW-1:0] rd;
      logic          err;
      logic [DW-1:0] exp_v;
      bit            exp_err;
      exp_err = (sb.size() == 0);
      exp_v   = exp_err ? '0 : sb.pop_front();
      apb(1'b0, 8'h00, '0, rd, err);
      check("rd_data_err", 32'(err), 32'(exp_err));
      check("rd_data_val", 32'(rd), 32'(exp_v));
   endtask

   task automatic rd_status();
      logic [DW-1:0] rd;
      logic          err;
      logic [31:0]   exp_v;
      exp_v = (32'(sb.size()) << 8) | (32'(sat_m) << 2) |
              (32'(sb.size() == DEPTH) << 1) | 32'(sb.size() == 0);
      apb(1'b0, 8'h04, '0, rd, err);
      check("status_err", 32'(err), 32'd0);
      check("status_val", 32'(rd), exp_v);
   endtask

   task automatic wr_ctrl(input logic [DW-1:0] v);
      logic [DW-1:0] rd;
      logic          err;
      apb(1'b1, 8'h08, v, rd, err);
      check("ctrl_err", 32'(err), 32'd0);
      if (v[0]) begin pred_m = 0; sb.delete(); end
      if (v[1]) sat_m = 1'b0;
   endtask

   task automatic access_err(input logic wr, input logic [7:0] addr, input logic exp_err);
      logic [DW-1:0] rd;
      logic          err;
      apb(wr, addr, 16'h0003, rd, err);
      check("misc_err", 32'(err), 32'(exp_err));
      check("misc_rdata", 32'(rd), 32'd0);
   endtask

   initial begin
      PRESETn = 1'b0; PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0;
      repeat (2) @(negedge PCLK);
      check("rst_pready", 32'(PREADY), 32'd1);
      check("rst_pslverr", 32'(PSLVERR), 32'd0);
      check("rst_prdata", 32'(PRDATA), 32'd0);
      check("rst_estados", 32'(estados), 32'd0);
      PRESETn = 1'b1;
      rd_status();

      // Basic reconstruction: 10, -3, 127 -> 10, 7, 134.
      wr_data(10); wr_data(-3); wr_data(127);
      rd_status();
      rd_data(); rd_data(); rd_data();
      rd_status();

      // Out-of-range differences are rejected without disturbing the predictor.
      wr_ctrl(16'h0001);
      wr_data(128); wr_data(-129);
      rd_status();
      wr_data(5);
      rd_data();

      // Other register-map corners.
      access_err(1'b1, 8'h04, 1'b1);
      access_err(1'b0, 8'h08, 1'b0);
      access_err(1'b0, 8'h0C, 1'b1);
      access_err(1'b1, 8'h01, 1'b1);
      rd_data();

      // Positive saturation and sticky flag clear.
      wr_ctrl(16'h0001);
      for (int i = 0; i < 260; i++) begin
         wr_data(127);
         rd_data();
      end
      wr_data(127);
      rd_status();
      rd_data();
      wr_ctrl(16'h0002);
      rd_status();

      // Negative saturation, then clear both at once.
      wr_ctrl(16'h0001);
      for (int i = 0; i < 258; i++) begin
         wr_data(-128);
         rd_data();
      end
      rd_status();
      wr_data(-1);
      wr_ctrl(16'h0003);
      rd_status();

      // Fill past full, drain past empty, then refill across the wrap.
      for (int i = 1; i <= 9; i++) wr_data(i * 3);
      rd_status();
      for (int i = 0; i < 9; i++) rd_data();
      for (int i = 0; i < 5; i++) wr_data(-7 * i);
      rd_status();
      for (int i = 0; i < 5; i++) rd_data();

      // Predictor clear between samples.
      wr_data(50);
      wr_ctrl(16'h0001);
      wr_data(4);
      rd_status();
      rd_data();

      // Reset asserted during the ACCESS cycle of a DATA write.
      wr_data(20);
      @(posedge PCLK); #1;
      PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 16'd9;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      for (int i = 0; i < 8 && estados != 2'd2; i++) @(negedge PCLK);
      check("mid_rst_reached_access", 32'(estados), 32'd2);
      PRESETn = 1'b0;
      pred_m = 0; sat_m = 1'b0; sb.delete();
      @(posedge PCLK); #1;
      PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      @(negedge PCLK);
      PRESETn = 1'b1;
      @(negedge PCLK);
      check("post_rst_pready", 32'(PREADY), 32'd1);
      check("post_rst_pslverr", 32'(PSLVERR), 32'd0);
      check("post_rst_estados", 32'(estados), 32'd0);
      rd_status();
      wr_data(6);
      rd_data();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dpcm_decoder_apb.md
Name: dpcm_decoder_apb

Overview:
- Downstream stage of the DPCM saturation encoder. It receives the saturated difference words the encoder produced, reconstructs the samples, and returns them.
- Operates as an APB slave. Host writes each difference to DATA; the block adds it to the last reconstructed sample, saturates the sum, and pushes the result into a small FIFO.
- Host reads reconstructed samples back from DATA in order. STATUS and CTRL registers provide flow control and predictor clearing.

Parameters:
- DATA_W, 32, width of reconstructed samples and of PWDATA/PRDATA.
- DIFF_W, 8, legal difference range is signed DIFF_W, i.e. [-2^(DIFF_W-1), 2^(DIFF_W-1)-1]; matches the encoder's saturation width.
- FIFO_DEPTH, 8, reconstructed-sample FIFO depth; power of two, at most 128.

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  asynchronous active-low reset
- PSELx  in  1  slave select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  32  byte address; only [7:0] decoded
- PWDATA  in  DATA_W  signed write data
- PREADY  out  1  transfer completion
- PSLVERR  out  1  error, valid when PREADY=1 in ACCESS
- PRDATA  out  DATA_W  signed read data
- estados  out  2  current FSM state, for debug

Behaviour:
- Reset: one clock, PCLK. Asynchronous active-low reset PRESETn; all state cleared while PRESETn=0.
  - PREADY=1, PSLVERR=0, PRDATA=0, estados=IDLE.
  - Predictor=0, FIFO empty (pointers 0, count 0), sat_sticky=0.
- FSM, enum {IDLE=0, SETUP=1, ACCESS=2}:
  - IDLE -> SETUP when PSELx && !PENABLE.
  - SETUP -> ACCESS unconditionally.
  - ACCESS -> completes when PREADY=1. Then -> SETUP if PSELx && !PENABLE (back-to-back transfer), else -> IDLE.
  - PENABLE in IDLE is ignored.
- Commit: register side effects happen only on the completing ACCESS edge, exactly once per transfer.
- Register map (PADDR[7:0]):
  - 0x00 DATA, write: diff = signed PWDATA.
    - Diff out of the DIFF_W range -> PSLVERR=1, no push, predictor unchanged.
    - FIFO full -> PSLVERR=1, no push, predictor unchanged.
    - Otherwise sum = predictor + diff in DATA_W+1 bits, clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. The clamped value becomes both the new predictor and the FIFO entry.
    - If clamping occurred, set sat_sticky.
  - 0x00 DATA, read: PRDATA = FIFO head during ACCESS; pop on completion.
    - FIFO empty -> PSLVERR=1, PRDATA=0, no pop.
  - 0x04 STATUS, read-only:
    - [0] empty, [1] full, [2] sat_sticky.
    - [15:8] count, 0..FIFO_DEPTH.
    - All other bits 0.
    - A write to STATUS -> PSLVERR=1.
  - 0x08 CTRL, write-only:
    - bit0=1: predictor=0 and FIFO flushed.
    - bit1=1: clear sat_sticky.
    - Both bits set in the same write perform both actions.
    - A read of CTRL returns 0 with PSLVERR=0.
  - Any other address -> PSLVERR=1, no side effects.
- Output timing:
  - PRDATA holds 0 outside ACCESS.
  - PSLVERR is 0 outside the completing ACCESS cycle.
- Latency:
  - Zero wait states: PREADY=1 throughout.
  - A written sample is readable on the very next transfer.
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH.
  - count distinguishes full from empty.
- Reset mid-transfer: FSM to IDLE, transfer dropped; no partial commit survives.

Optional Feature:
- Macro DPCM_DEC_WAIT_EN.
- Defined:
  - Adds FSM state WAIT=3. ACCESS of every DATA read first drives PREADY=0 and enters WAIT.
  - WAIT registers the FIFO head into PRDATA and drives PREADY=1, completing the transfer there.
  - Pop/error evaluated in WAIT.
  - All other accesses remain zero-wait.
- Undefined:
  - No WAIT state; PREADY is constant 1.
  - estados never equals 3.

Decomposition:
- Package dpcm_pkg holds:
  - State enum typedef.
  - Register offsets: ADDR_DATA, ADDR_STATUS, ADDR_CTRL.
  - STATUS/CTRL bit-index constants.
  - Saturation function sat_add(a, b) returning the clamped DATA_W sum. The encoder side can reuse it.
- One sub-module, dpcm_sample_fifo:
  - Parameterised by DATA_W and FIFO_DEPTH.
  - Ports: push, pop, flush, din, dout, count, full, empty.
  - Async active-low reset on PRESETn.

Test Plan:
- Reset then write DATA 10, -3, 127 -> read DATA three times returns 10, 7, 134; STATUS reads empty=1, count=0.
- Write DATA 128 (out of range, DIFF_W=8) -> PSLVERR=1; STATUS count=0; next write 5 then read returns 5.
- Set predictor near max with DATA writes of 127, then continue with 127s -> result clamps at 0x7FFFFFFF and STATUS[2]=1. Write CTRL=0x2 -> STATUS[2]=0.
- Write 9 samples with FIFO_DEPTH=8 -> 9th write PSLVERR=1 and STATUS full=1, count=8. Read 9 times -> 9th read PSLVERR=1 with PRDATA=0. Pointers wrap correctly on a refill.
- Write 50, write CTRL=0x1, then write 4 -> read returns 4 (predictor cleared); STATUS count=1 after that write.
- Assert PRESETn=0 during ACCESS of a DATA write -> no push; after release PREADY=1, PSLVERR=0, estados=0, STATUS empty=1.
